// File: rtl/instr_fetch24_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | instr_fetch24_if : fetch <-> ROM / decode / execute signal bundle     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface instr_fetch24_if #(
  parameter int AW = 10
);
  logic          start;
  logic [AW-1:0] rom_addr;
  logic [23:0]   rom_instr;
  logic          stall;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          instr_valid;
  logic [23:0]   instr_out;
  logic [AW-1:0] instr_pc;
  logic          halted;

  modport master (
    input  start, rom_instr, stall, redirect_valid, redirect_addr,
    output rom_addr, instr_valid, instr_out, instr_pc, halted
  );

  modport slave (
    output start, rom_instr, stall, redirect_valid, redirect_addr,
    input  rom_addr, instr_valid, instr_out, instr_pc, halted
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch24.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | instr_fetch24 : PC sequencer for a 24-bit synchronous instruction ROM |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module instr_fetch24 #(
  parameter int          AW           = 10,
  parameter int unsigned RESET_PC     = 0,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  wire             clk,
  input  wire             rst,
  instr_fetch24_if.master bus
);

  localparam logic [AW-1:0] c_RESET_PC = AW'(RESET_PC);
  localparam logic [AW-1:0] c_ONE      = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_fetch_pc;
  logic [AW-1:0] r_req_pc;
  logic          r_req_vld;

  logic w_run;
  logic w_start_go;
  logic w_redir;
  logic w_valid;
  logic w_halt;

  assign w_run      = (r_state == S_RUN);
  assign w_start_go = bus.start & ~w_run;
  assign w_redir    = bus.redirect_valid & w_run;
  assign w_valid    = w_run & r_req_vld & ~bus.redirect_valid;
  // A halt word only takes effect once decode actually accepts it.
  assign w_halt     = HALT_ON_ZERO & w_valid & ~bus.stall & (bus.rom_instr == 24'h000000);

  // During a stall the ROM re-reads the held address so its output stays put.
  assign bus.rom_addr    = w_start_go                ? c_RESET_PC        :
                           w_redir                   ? bus.redirect_addr :
                           (bus.stall & r_req_vld)   ? r_req_pc          :
                                                       r_fetch_pc;
  assign bus.instr_valid = w_valid;
  assign bus.instr_out   = bus.rom_instr;
  assign bus.instr_pc    = r_req_pc;
  assign bus.halted      = (r_state == S_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= c_RESET_PC;
      r_req_pc   <= c_RESET_PC;
      r_req_vld  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (bus.start) begin
            r_state    <= S_RUN;
            r_req_pc   <= c_RESET_PC;
            r_req_vld  <= 1'b1;
            r_fetch_pc <= c_RESET_PC + c_ONE;
          end
        end
        S_RUN: begin
          if (bus.redirect_valid) begin
            r_req_pc   <= bus.redirect_addr;
            r_req_vld  <= 1'b1;
            r_fetch_pc <= bus.redirect_addr + c_ONE;
          end else if (!bus.stall) begin
            if (w_halt) begin
              r_state   <= S_HALT;
              r_req_vld <= 1'b0;
            end else begin
              r_req_pc   <= r_fetch_pc;
              r_req_vld  <= 1'b1;
              r_fetch_pc <= r_fetch_pc + c_ONE;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_req_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
